// File: rtl/alu_wide_seq.sv
// alu_wide_seq: sequences an N_BYTES-wide op as byte ops on an 8-bit alu, chaining carry.
module alu_wide_seq #(
  parameter int N_BYTES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [8*N_BYTES-1:0] req_a,
  input  logic [8*N_BYTES-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*N_BYTES-1:0] rsp_result,
  output logic                 rsp_cf,
  output logic                 rsp_zf,
  output logic                 rsp_sf,
  output logic                 rsp_err,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_op,
  input  logic [7:0]           alu_result,
  input  logic                 alu_cf
);
  localparam int W = 8 * N_BYTES;
  localparam logic [1:0] LAST = 2'(N_BYTES - 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBC = 4'd3,
                         OP_AND = 4'd4, OP_SHL = 4'd8, OP_SHR = 4'd9, OP_SAL = 4'd10,
                         OP_SAR = 4'd11, OP_RCL = 4'd12, OP_RCR = 4'd13;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q;
  logic [W-1:0] a_q, b_q, res_q, res_d;
  logic [1:0] cnt_q, idx, prev_idx_q;
  logic cf_q, zf_q, err_q, msb_first, supported, cap;
  logic [3:0] first_op, later_op;
  assign msb_first = (op_q == OP_SHR) || (op_q == OP_SAR);
  assign idx = msb_first ? LAST - cnt_q : cnt_q;
  assign first_op = (op_q == OP_SAL) ? OP_SHL : op_q;
  assign later_op = (op_q == OP_ADD) ? OP_ADC :
                    (op_q == OP_SUB) ? OP_SBC :
                    (op_q == OP_SHL || op_q == OP_SAL) ? OP_RCL :
                    (op_q == OP_SHR || op_q == OP_SAR) ? OP_RCR : op_q;
  assign supported = !(req_op == OP_ADC || req_op == OP_SBC || req_op >= OP_RCL);
  // The result for the byte issued last cycle lands this cycle; FLUSH catches the final one.
  assign cap = (state_q == RUN && cnt_q != 2'd0) || (state_q == FLUSH && !err_q);
  always_comb begin
    res_d = res_q;
    if (cap) res_d[8*prev_idx_q +: 8] = alu_result;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = req_valid ? (supported ? RUN : FLUSH) : IDLE;
      RUN:   state_d = (cnt_q == LAST) ? FLUSH : RUN;
      FLUSH: state_d = DONE;
      DONE:  state_d = rsp_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      prev_idx_q <= '0;
      cf_q       <= 1'b0;
      zf_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        cnt_q <= '0;
        res_q <= '0;
        cf_q  <= 1'b0;
        zf_q  <= 1'b0;
        err_q <= !supported;
      end
      if (state_q == RUN) begin
        cnt_q      <= cnt_q + 2'd1;
        prev_idx_q <= idx;
      end
      if (cap) res_q <= res_d;
      if (state_q == FLUSH && !err_q) begin
        cf_q <= alu_cf;
        zf_q <= (res_d == '0);
      end
    end
  end
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = res_q;
  assign rsp_cf     = cf_q;
  assign rsp_zf     = zf_q;
  assign rsp_sf     = res_q[W-1];
  assign rsp_err    = err_q;
  assign alu_op     = (state_q == RUN) ? ((cnt_q == 2'd0) ? first_op : later_op) : OP_AND;
  assign alu_a      = (state_q == RUN) ? a_q[8*idx +: 8] : 8'd0;
  assign alu_b      = (state_q == RUN) ? b_q[8*idx +: 8] : 8'd0;
endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: directed checks of alu_wide_seq (N_BYTES=2) against a behavioural byte alu.
module tb_alu_wide_seq;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0] req_op = 4'd0;
  logic [15:0] req_a = 16'd0, req_b = 16'd0;
  logic req_ready, rsp_valid, rsp_cf, rsp_zf, rsp_sf, rsp_err;
  logic [15:0] rsp_result;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  logic alu_cf;
  int checks = 0, failures = 0;
  int lat;
  logic [3:0] ops0, ops1;
  logic [7:0] a0, a1;

  always #5 clk = ~clk;

  alu_wide_seq #(.N_BYTES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_cf(rsp_cf), .rsp_zf(rsp_zf),
    .rsp_sf(rsp_sf), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cf(alu_cf)
  );

  // Registered byte alu with RCL=12, RCR=13.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c);
    case (op)
      4'd0:  return {1'b0, a} + {1'b0, b};
      4'd1:  return {1'b0, a} - {1'b0, b};
      4'd2:  return {1'b0, a} + {1'b0, b} + {8'd0, c};
      4'd3:  return {1'b0, a} - {1'b0, b} - {8'd0, c};
      4'd4:  return {1'b0, a & b};
      4'd5:  return {1'b0, a | b};
      4'd6:  return {1'b0, ~b};
      4'd7:  return {1'b0, a ^ b};
      4'd8, 4'd10: return {a[7], a[6:0], 1'b0};
      4'd9:  return {a[0], 1'b0, a[7:1]};
      4'd11: return {a[0], a[7], a[7:1]};
      4'd12: return {a[7], a[6:0], c};
      4'd13: return {a[0], c, a[7:1]};
      default: return 9'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) {alu_cf, alu_result} <= 9'd0;
    else {alu_cf, alu_result} <= alu_f(alu_op, alu_a, alu_b, alu_cf);
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'hF; req_a = 16'hDEAD; req_b = 16'hBEEF;
    lat = 0; ops0 = alu_op; a0 = alu_a; ops1 = 4'hF; a1 = 8'hFF;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin ops1 = alu_op; a1 = alu_a; end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_result !== 16'h0) begin failures++; $display("FAIL reset_result got=%h exp=0000", rsp_result); end
    checks++; if ({rsp_cf, rsp_zf, rsp_sf, rsp_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {rsp_cf, rsp_zf, rsp_sf, rsp_err}); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if ({alu_op, alu_a, alu_b} !== {4'd4, 16'd0}) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=4/00/00", alu_op, alu_a, alu_b); end
  endtask

  task automatic test_add();
    issue(4'd0, 16'h00FF, 16'h0001);
    checks++; if (lat !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
    checks++; if ({ops0, ops1} !== {4'd0, 4'd2}) begin failures++; $display("FAIL add_ops got=%h,%h exp=0,2", ops0, ops1); end
    checks++; if (rsp_result !== 16'h0100) begin failures++; $display("FAIL add_result got=%h exp=0100", rsp_result); end
    checks++; if ({rsp_cf, rsp_zf, rsp_sf, rsp_err} !== 4'b0000) begin failures++; $display("FAIL add_flags got=%b exp=0000", {rsp_cf, rsp_zf, rsp_sf, rsp_err}); end
    checks++; if ({req_ready, alu_op} !== {1'b0, 4'd4}) begin failures++; $display("FAIL done_idle_outputs got=%b/%h exp=0/4", req_ready, alu_op); end
    consume();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL consume got=%b exp=01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_sub();
    issue(4'd1, 16'h0000, 16'h0001);
    checks++; if ({ops0, ops1} !== {4'd1, 4'd3}) begin failures++; $display("FAIL sub_ops got=%h,%h exp=1,3", ops0, ops1); end
    checks++; if (rsp_result !== 16'hFFFF) begin failures++; $display("FAIL sub_result got=%h exp=ffff", rsp_result); end
    checks++; if ({rsp_cf, rsp_zf, rsp_sf, rsp_err} !== 4'b1010) begin failures++; $display("FAIL sub_flags got=%b exp=1010", {rsp_cf, rsp_zf, rsp_sf, rsp_err}); end
    consume();
  endtask

  task automatic test_shifts();
    issue(4'd9, 16'h0001, 16'h0000);
    checks++; if ({ops0, a0, ops1, a1} !== {4'd9, 8'h00, 4'd13, 8'h01}) begin failures++; $display("FAIL shr_seq got=%h/%h,%h/%h exp=9/00,d/01", ops0, a0, ops1, a1); end
    checks++; if ({rsp_result, rsp_cf, rsp_zf, rsp_sf} !== {16'h0000, 3'b110}) begin failures++; $display("FAIL shr_rsp got=%h %b exp=0000 110", rsp_result, {rsp_cf, rsp_zf, rsp_sf}); end
    consume();
    issue(4'd11, 16'h8002, 16'h0000);
    checks++; if ({ops0, a0, ops1, a1} !== {4'd11, 8'h80, 4'd13, 8'h02}) begin failures++; $display("FAIL sar_seq got=%h/%h,%h/%h exp=b/80,d/02", ops0, a0, ops1, a1); end
    checks++; if ({rsp_result, rsp_cf, rsp_zf, rsp_sf} !== {16'hC001, 3'b001}) begin failures++; $display("FAIL sar_rsp got=%h %b exp=c001 001", rsp_result, {rsp_cf, rsp_zf, rsp_sf}); end
    consume();
    issue(4'd10, 16'h4081, 16'h0000);
    checks++; if ({ops0, a0, ops1, a1} !== {4'd8, 8'h81, 4'd12, 8'h40}) begin failures++; $display("FAIL sal_seq got=%h/%h,%h/%h exp=8/81,c/40", ops0, a0, ops1, a1); end
    checks++; if ({rsp_result, rsp_cf, rsp_zf, rsp_sf} !== {16'h8102, 3'b001}) begin failures++; $display("FAIL sal_rsp got=%h %b exp=8102 001", rsp_result, {rsp_cf, rsp_zf, rsp_sf}); end
    consume();
  endtask

  task automatic test_logic();
    issue(4'd7, 16'h1234, 16'h1234);
    checks++; if ({ops0, ops1} !== {4'd7, 4'd7}) begin failures++; $display("FAIL xor_ops got=%h,%h exp=7,7", ops0, ops1); end
    checks++; if ({rsp_result, rsp_zf, rsp_sf} !== {16'h0000, 2'b10}) begin failures++; $display("FAIL xor_rsp got=%h zf=%b sf=%b exp=0000 1 0", rsp_result, rsp_zf, rsp_sf); end
    consume();
    issue(4'd6, 16'h0000, 16'h00F0);
    checks++; if ({rsp_result, rsp_zf, rsp_sf} !== {16'hFF0F, 2'b01}) begin failures++; $display("FAIL not_rsp got=%h zf=%b sf=%b exp=ff0f 0 1", rsp_result, rsp_zf, rsp_sf); end
    consume();
  endtask

  task automatic test_err();
    issue(4'hC, 16'h1234, 16'h5678);
    checks++; if (lat !== 1) begin failures++; $display("FAIL err_latency got=%0d exp=1", lat); end
    checks++; if ({rsp_result, rsp_cf, rsp_zf, rsp_sf, rsp_err} !== {16'h0, 4'b0001}) begin failures++; $display("FAIL err_rsp got=%h %b exp=0000 0001", rsp_result, {rsp_cf, rsp_zf, rsp_sf, rsp_err}); end
    checks++; if (ops0 !== 4'd4) begin failures++; $display("FAIL err_no_run got=%h exp=4", ops0); end
    consume();
    issue(4'd2, 16'h0001, 16'h0001);
    checks++; if ({lat, rsp_err, rsp_result} !== {32'd1, 1'b1, 16'h0}) begin failures++; $display("FAIL adc_err got=lat%0d err%b %h exp=lat1 err1 0000", lat, rsp_err, rsp_result); end
    consume();
  endtask

  task automatic test_hold();
    issue(4'd0, 16'h1111, 16'h2222);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_result, rsp_cf, rsp_zf, rsp_sf, rsp_err} !== {2'b10, 16'h3333, 4'b0000}) begin
        failures++; $display("FAIL hold_%0d got=%b%b %h %b exp=10 3333 0000", i, rsp_valid, req_ready, rsp_result, {rsp_cf, rsp_zf, rsp_sf, rsp_err});
      end
    end
    consume();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; req_a = 16'h0102; req_b = 16'h0304;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({req_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL reset_mid got=%b exp=10", {req_ready, rsp_valid}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_drop_%0d got=%b exp=0", i, rsp_valid); end
    end
  endtask

  task automatic test_back_to_back();
    issue(4'd5, 16'h0F00, 16'h00F0);
    checks++; if (rsp_result !== 16'h0FF0) begin failures++; $display("FAIL b2b_first got=%h exp=0ff0", rsp_result); end
    consume();
    issue(4'd4, 16'hFF0F, 16'h0FFF);
    checks++; if ({rsp_result, lat} !== {16'h0F0F, 32'd3}) begin failures++; $display("FAIL b2b_second got=%h lat%0d exp=0f0f lat3", rsp_result, lat); end
    consume();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shifts();
    test_logic();
    test_err();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
